// File: rtl/fetch_stage.sv
// Fetch stage: PC register plus IF/ID pipeline register, with flush/stall event counters.
// One-clock fetch-to-IF/ID latency; a stall holds the PC and IF/ID, a flush redirects the PC and inserts a bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      branch_target_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_data_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      ifid_pc_o,
  output logic [31:0]      ifid_instr_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic   do_flush, do_stall, do_adv;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The edge that leaves RUN (start_i low) takes no pipeline action.
  always_comb begin
    state_d  = state_q;
    do_flush = 1'b0;
    do_stall = 1'b0;
    do_adv   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (!start_i)     state_d  = IDLE;
        else if (flush_i) do_flush = 1'b1;
        else if (stall_i) do_stall = 1'b1;
        else              do_adv   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_o         <= RESET_PC;
      ifid_pc_o    <= 32'h0;
      ifid_instr_o <= 32'h0;
      ifid_valid_o <= 1'b0;
      stall_cnt_o  <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (do_flush) begin
        pc_o         <= branch_target_i;
        ifid_pc_o    <= 32'h0;
        ifid_instr_o <= 32'h0;
        ifid_valid_o <= 1'b0;
        if (flush_cnt_o != CNT_MAX) flush_cnt_o <= flush_cnt_o + CNT_ONE;
      end else if (do_stall) begin
        if (stall_cnt_o != CNT_MAX) stall_cnt_o <= stall_cnt_o + CNT_ONE;
      end else if (do_adv) begin
        pc_o         <= pc_o + 32'd4;
        ifid_pc_o    <= pc_o;
        ifid_instr_o <= imem_data_i;
        ifid_valid_o <= 1'b1;
      end
    end
  end

  assign imem_addr_o = pc_o;
  assign state_o     = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns its own address as the instruction word.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, start, stall, flush;
  logic [31:0] bt;
  logic [31:0] imem_addr, pc, ifid_pc, ifid_instr;
  logic        ifid_valid, state;
  logic [31:0] stall_cnt, flush_cnt;

  logic        b_rst, b_start, b_stall;
  logic [31:0] b_imem_addr, b_pc, b_ifid_pc, b_ifid_instr;
  logic        b_ifid_valid, b_state;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .branch_target_i(bt), .imem_addr_o(imem_addr), .imem_data_i(imem_addr),
    .pc_o(pc), .ifid_pc_o(ifid_pc), .ifid_instr_o(ifid_instr), .ifid_valid_o(ifid_valid),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .state_o(state)
  );

  fetch_stage #(.RESET_PC(32'h0), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .start_i(b_start), .stall_i(b_stall), .flush_i(1'b0),
    .branch_target_i(32'h0), .imem_addr_o(b_imem_addr), .imem_data_i(b_imem_addr),
    .pc_o(b_pc), .ifid_pc_o(b_ifid_pc), .ifid_instr_o(b_ifid_instr), .ifid_valid_o(b_ifid_valid),
    .stall_cnt_o(b_stall_cnt), .flush_cnt_o(b_flush_cnt), .state_o(b_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " pc"}, pc, 32'h0);
    chk({tag, " ifid_pc"}, ifid_pc, 32'h0);
    chk({tag, " ifid_instr"}, ifid_instr, 32'h0);
    chk({tag, " ifid_valid"}, {31'b0, ifid_valid}, 32'h0);
    chk({tag, " stall_cnt"}, stall_cnt, 32'h0);
    chk({tag, " flush_cnt"}, flush_cnt, 32'h0);
    chk({tag, " state"}, {31'b0, state}, 32'h0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0; bt = 32'h0;
    b_rst = 1'b0; b_start = 1'b0; b_stall = 1'b0;
    tick();
    chk_reset_vals("reset");
    chk("reset imem_addr", imem_addr, 32'h0);

    // First edge with start only enters RUN.
    rst = 1'b1; start = 1'b1; b_rst = 1'b1;
    tick();
    chk("enter run state", {31'b0, state}, 32'h1);
    chk("enter run pc", pc, 32'h0);
    chk("enter run valid", {31'b0, ifid_valid}, 32'h0);

    tick(); tick(); tick();
    chk("run3 pc", pc, 32'd12);
    chk("run3 ifid_pc", ifid_pc, 32'd8);
    chk("run3 ifid_instr", ifid_instr, 32'd8);
    chk("run3 ifid_valid", {31'b0, ifid_valid}, 32'h1);
    chk("run3 imem_addr", imem_addr, 32'd12);

    tick();
    chk("pc16", pc, 32'd16);
    stall = 1'b1;
    tick(); tick();
    chk("stall pc", pc, 32'd16);
    chk("stall ifid_pc", ifid_pc, 32'd12);
    chk("stall ifid_instr", ifid_instr, 32'd12);
    chk("stall ifid_valid", {31'b0, ifid_valid}, 32'h1);
    chk("stall stall_cnt", stall_cnt, 32'd2);
    chk("stall flush_cnt", flush_cnt, 32'd0);

    flush = 1'b1; bt = 32'h40;
    tick();
    chk("flush pc", pc, 32'h40);
    chk("flush ifid_valid", {31'b0, ifid_valid}, 32'h0);
    chk("flush ifid_instr", ifid_instr, 32'h0);
    chk("flush ifid_pc", ifid_pc, 32'h0);
    chk("flush flush_cnt", flush_cnt, 32'd1);
    chk("flush stall_cnt", stall_cnt, 32'd2);

    stall = 1'b0; flush = 1'b0;
    tick();
    chk("post flush pc", pc, 32'h44);
    chk("post flush ifid_pc", ifid_pc, 32'h40);
    chk("post flush ifid_instr", ifid_instr, 32'h40);

    flush = 1'b1; bt = 32'hFFFF_FFFC;
    tick();
    chk("wrap setup pc", pc, 32'hFFFF_FFFC);
    flush = 1'b0;
    tick();
    chk("wrap pc", pc, 32'h0);
    chk("wrap ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap ifid_instr", ifid_instr, 32'hFFFF_FFFC);

    flush = 1'b1; bt = 32'h103;
    tick();
    chk("unaligned pc", pc, 32'h103);
    flush = 1'b0;
    tick();
    chk("unaligned next pc", pc, 32'h107);
    chk("unaligned ifid_pc", ifid_pc, 32'h103);
    chk("flush_cnt 3", flush_cnt, 32'd3);

    // Reset held low between edges must not disturb outputs.
    rst = 1'b0; start = 1'b1; stall = 1'b1; flush = 1'b1; bt = 32'h80;
    #3;
    chk("no async pc", pc, 32'h107);
    chk("no async state", {31'b0, state}, 32'h1);
    chk("no async flush_cnt", flush_cnt, 32'd3);
    tick();
    chk_reset_vals("midrun reset");

    rst = 1'b1; start = 1'b0;
    tick(); tick(); tick(); tick();
    chk_reset_vals("idle freeze");

    start = 1'b1; stall = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("restart pc", pc, 32'd4);
    start = 1'b0; flush = 1'b1; bt = 32'h200;
    tick();
    chk("leave run state", {31'b0, state}, 32'h0);
    chk("leave run pc", pc, 32'd4);
    chk("leave run flush_cnt", flush_cnt, 32'd0);
    chk("leave run ifid_pc", ifid_pc, 32'd0);

    // Two-bit counter saturation.
    b_start = 1'b1;
    tick();
    chk("sat state", {31'b0, b_state}, 32'h1);
    b_stall = 1'b1;
    tick(); chk("sat cnt 1", {30'b0, b_stall_cnt}, 32'd1);
    tick(); chk("sat cnt 2", {30'b0, b_stall_cnt}, 32'd2);
    tick(); chk("sat cnt 3", {30'b0, b_stall_cnt}, 32'd3);
    tick(); chk("sat cnt 4", {30'b0, b_stall_cnt}, 32'd3);
    tick(); chk("sat cnt 5", {30'b0, b_stall_cnt}, 32'd3);
    chk("sat pc held", b_pc, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
Parameters:
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have parameter CNT_W, default 32, width of the stall/flush event counters.
Ports:
REQ-003 SHALL have clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have rst_i  input  1  reset, synchronous, active-low (0 = reset, sampled on rising clk_i).
REQ-005 SHALL have start_i  input  1  run enable; 0 freezes fetch.
REQ-006 SHALL have stall_i  input  1  load-use stall from hazard detection; hold PC and IF/ID.
REQ-007 SHALL have flush_i  input  1  branch taken in ID; redirect PC and squash IF/ID.
REQ-008 SHALL have branch_target_i  input  32  redirect address, valid when flush_i=1.
REQ-009 SHALL have imem_addr_o  output  32  instruction memory address (= current PC).
REQ-010 SHALL have imem_data_i  input  32  instruction word, combinational read of imem_addr_o, same cycle.
REQ-011 SHALL have pc_o  output  32  current PC register.
REQ-012 SHALL have ifid_pc_o  output  32  PC of instruction held in IF/ID.
REQ-013 SHALL have ifid_instr_o  output  32  instruction held in IF/ID.
REQ-014 SHALL have ifid_valid_o  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-015 SHALL have stall_cnt_o  output  CNT_W  count of stall-only cycles.
REQ-016 SHALL have flush_cnt_o  output  CNT_W  count of flush cycles.
REQ-017 SHALL have state_o  output  1  0 = IDLE, 1 = RUN.

Function
REQ-018 SHALL implement two states: IDLE and RUN; IDLE->RUN on rising edge with start_i=1; RUN->IDLE on rising edge with start_i=0.
REQ-019 In IDLE, SHALL hold PC, IF/ID and counters unchanged; stall_i/flush_i ignored.
REQ-020 In RUN, per cycle priority SHALL be flush > stall > normal advance.
REQ-021 Flush (RUN, flush_i=1): PC <= branch_target_i; IF/ID <= bubble (instr 32'b0, pc 0, valid 0); flush_cnt_o +1; stall_cnt_o unchanged even if stall_i=1.
REQ-022 Stall (RUN, stall_i=1, flush_i=0): PC and IF/ID hold all values; stall_cnt_o +1.
REQ-023 Normal (RUN, stall_i=0, flush_i=0): IF/ID <= {pc_o, imem_data_i, valid 1}; PC <= pc_o + 4.
REQ-024 PC increment SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 = 0), no flag.
REQ-025 imem_addr_o SHALL equal pc_o combinationally at all times.
REQ-026 Fetch-to-IF/ID latency SHALL be exactly one clock for a non-stalled, non-flushed cycle.
REQ-027 Counters SHALL saturate at all-ones (no wrap).
REQ-028 The RUN->IDLE edge SHALL not itself perform an advance/stall/flush action (start_i sampled 0 means freeze that edge).
REQ-029 branch_target_i low two bits SHALL be passed through unmodified (no alignment correction).

Reset
REQ-030 On rising clk_i with rst_i=0: state IDLE, pc_o=RESET_PC, ifid_pc_o=0, ifid_instr_o=0, ifid_valid_o=0, stall_cnt_o=0, flush_cnt_o=0.
REQ-031 Reset SHALL override start_i, stall_i, flush_i in the same cycle, including reset asserted mid-RUN.
REQ-032 With rst_i=0 between edges, outputs SHALL keep prior values until the next rising edge (no asynchronous effect).

Verification
REQ-033 Reset then start_i=1, imem returns word = address: after 3 RUN edges pc_o=12, ifid_pc_o=8, ifid_instr_o=8, ifid_valid_o=1.
REQ-034 stall_i=1 for 2 cycles at pc_o=16: pc_o stays 16, IF/ID unchanged, stall_cnt_o=2, flush_cnt_o=0.
REQ-035 flush_i=1 and stall_i=1 same cycle, branch_target_i=0x40: next pc_o=0x40, ifid_valid_o=0, ifid_instr_o=0, flush_cnt_o=1, stall_cnt_o unchanged.
REQ-036 pc forced via flush to 0xFFFF_FFFC then one normal cycle: pc_o=0, ifid_pc_o=0xFFFF_FFFC.
REQ-037 rst_i=0 for one edge mid-RUN with counters nonzero: all outputs equal REQ-030 values, state_o=0; start_i=0 then freezes everything for 4 cycles.
REQ-038 CNT_W=2, stall 5 cycles: stall_cnt_o sequence 1,2,3,3,3.
